// File: rtl/seg7_scan_reader_if.sv
// Bus between a scanned active-low seven-segment display and its reader.
// The master drives segments/strobes; the slave returns decoded digits and status.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              i_seg7;
    logic [NUM_DIGITS-1:0]   i_an;
    logic [4*NUM_DIGITS-1:0] o_digits;
    logic [NUM_DIGITS-1:0]   o_valid;
    logic                    o_update;
    logic                    o_err;
    logic                    o_frame;

    // There is no back-pressure: i_seg7/i_an are sampled on every clock edge,
    // and o_update/o_err/o_frame are single-cycle pulses that must be consumed
    // on the cycle they are high. o_digits/o_valid hold until the next capture.
    modport master (
        output i_seg7, i_an,
        input  o_digits, o_valid, o_update, o_err, o_frame
    );

    modport slave (
        input  i_seg7, i_an,
        output o_digits, o_valid, o_update, o_err, o_frame
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers decimal digits from a multiplexed active-low seven-segment bus.
// Define SEG7_BLANK_EN to accept the all-off pattern as a legal blank (4'hF).
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    seg7_scan_reader_if.slave    bus,
    output logic [1:0]           o_state
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int SW = NUM_DIGITS + 7;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [SW-1:0]           r;
    logic [SW-1:0]           cur;
    logic [CW-1:0]           cnt;
    logic                    same;
    logic                    sel;
    logic [3:0]              zcnt;
    logic [IW-1:0]           idx;
    logic                    capture;
    logic                    legal;
    logic [3:0]              value;
    logic [NUM_DIGITS-1:0]   seen, seen_next;
    logic                    frame_hit;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   valid;
    logic                    update, err, frame;

    assign cur  = {bus.i_an, bus.i_seg7};
    assign same = (cur == r);

    // A strobe is selected only when exactly one anode is pulled low.
    always_comb begin
        zcnt = 4'd0;
        idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bus.i_an[i]) begin
                zcnt = zcnt + 4'd1;
                idx  = IW'(i);
            end
        end
        sel = (zcnt == 4'd1);
    end

    always_comb begin
        legal = 1'b1;
        value = 4'd0;
        case (bus.i_seg7)
            7'b1000000: value = 4'd0;
            7'b1111001: value = 4'd1;
            7'b0100100: value = 4'd2;
            7'b0110000: value = 4'd3;
            7'b0011001: value = 4'd4;
            7'b0010010: value = 4'd5;
            7'b0000010: value = 4'd6;
            7'b1011000: value = 4'd7;
            7'b0000000: value = 4'd8;
            7'b0010000: value = 4'd9;
`ifdef SEG7_BLANK_EN
            7'b1111111: value = 4'hF;
`endif
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (sel) state_next = SETTLE;
            end
            SETTLE: begin
                if (!sel) begin
                    state_next = IDLE;
                end else if (same && cnt == CNT_MAX) begin
                    capture    = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!sel)       state_next = IDLE;
                else if (!same) state_next = SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seen_next = seen | (NUM_DIGITS'(1) << idx);
        frame_hit = &seen_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r      <= '1;
            cnt    <= '0;
            seen   <= '0;
            digits <= '0;
            valid  <= '0;
            update <= 1'b0;
            err    <= 1'b0;
            frame  <= 1'b0;
        end else begin
            r <= cur;
            if (!same)               cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            update <= capture;
            err    <= capture & ~legal;
            frame  <= capture & frame_hit;
            if (capture) begin
                // An illegal pattern keeps the last good value but drops its valid flag.
                if (legal) digits[4*idx +: 4] <= value;
                valid[idx] <= legal;
                seen       <= frame_hit ? '0 : seen_next;
            end
        end
    end

    assign bus.o_digits = digits;
    assign bus.o_valid  = valid;
    assign bus.o_update = update;
    assign bus.o_err    = err;
    assign bus.o_frame  = frame;
    assign o_state      = state;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed and randomized bench for seg7_scan_reader against a run-length
// reference model of the display bus.
module tb_seg7_scan_reader;
    localparam int ND = 4;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dut_state;

    always #5 clk = ~clk;

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus),
        .o_state (dut_state)
    );

    logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                                 7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_errors = 0;
    string phase = "reset";

    // reference model: a capture happens when a selected sample has repeated
    // for exactly SC further edges since it first appeared
    logic [ND+6:0]   m_prev;
    int              m_run;
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_seen;
    logic            m_update, m_err, m_frame;
    logic [15:0]     exp_q[$];

    int n_upd = 0;
    int n_err_obs = 0;
    int n_frame_obs = 0;
    int frame_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = '1;
        m_run    = 0;
        m_digits = '0;
        m_valid  = '0;
        m_seen   = '0;
        m_update = 1'b0;
        m_err    = 1'b0;
        m_frame  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [ND-1:0] an, input logic [6:0] seg);
        logic [ND+6:0] smp;
        bit            ok;
        logic [3:0]    v;
        int            idx;
        smp = {an, seg};
        if (smp == m_prev) m_run++;
        else               m_run = 0;
        m_prev   = smp;
        m_update = 1'b0;
        m_err    = 1'b0;
        m_frame  = 1'b0;
        if ($countones(~an) == 1 && m_run == SC) begin
            idx = 0;
            for (int k = 0; k < ND; k++) if (!an[k]) idx = k;
            ok = 1'b0;
            v  = 4'd0;
            for (int k = 0; k < 10; k++) if (seg == pat_tab[k]) begin ok = 1'b1; v = 4'(k); end
`ifdef SEG7_BLANK_EN
            if (seg == 7'h7F) begin ok = 1'b1; v = 4'hF; end
`endif
            if (ok) m_digits[4*idx +: 4] = v;
            m_valid[idx] = ok;
            m_update = 1'b1;
            m_err    = !ok;
            m_seen[idx] = 1'b1;
            if (&m_seen) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
            exp_q.push_back({6'b0, m_frame, m_err, ok, 3'(idx), m_digits[4*idx +: 4]});
        end
    endtask

    task automatic check_outputs();
        logic [15:0] rec, obs;
        int          i;
        check("update", 32'(bus.o_update), 32'(m_update));
        check("err",    32'(bus.o_err),    32'(m_err));
        check("frame",  32'(bus.o_frame),  32'(m_frame));
        check("digits", 32'(bus.o_digits), 32'(m_digits));
        check("valid",  32'(bus.o_valid),  32'(m_valid));
        if (bus.o_update === 1'b1) begin
            n_upd++;
            if (bus.o_err === 1'b1) n_err_obs++;
            if (bus.o_frame === 1'b1) begin
                n_frame_obs++;
                frame_at = n_upd;
            end
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                rec = exp_q.pop_front();
                i   = int'(rec[6:4]);
                obs = {6'b0, bus.o_frame, bus.o_err, bus.o_valid[i], rec[6:4], bus.o_digits[4*i +: 4]};
                check("sb_capture", 32'(obs), 32'(rec));
            end
        end
    endtask

    task automatic step(input logic [ND-1:0] an, input logic [6:0] seg);
        bus.i_an   = an;
        bus.i_seg7 = seg;
        @(posedge clk);
        model_edge(an, seg);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) step(an, seg);
    endtask

    initial begin
        int  u0, e0, f0, found;
        logic [ND-1:0] ran;
        logic [6:0]    rseg;

        rst        = 1'b1;
        bus.i_an   = '1;
        bus.i_seg7 = '1;
        model_reset();
        #22;
        check_outputs();
        rst = 1'b0;

        phase = "latency";
        u0 = n_upd;
        hold(4'b1110, 7'b0100100, SC);
        check("no_early_update", 32'(n_upd - u0), 32'd0);
        step(4'b1110, 7'b0100100);
        check("update_at_edge_sc", 32'(bus.o_update), 32'd1);
        check("digit0_is_2", 32'(bus.o_digits[3:0]), 32'd2);
        check("valid_0001", 32'(bus.o_valid), 32'b0001);
        hold(4'b1110, 7'b0100100, 3);

        phase = "glitch";
        u0 = n_upd;
        hold(4'b1101, 7'b0110000, 3);
        hold(4'b1101, 7'b1111001, 10);
        check("single_capture", 32'(n_upd - u0), 32'd1);
        check("digit1_is_1", 32'(bus.o_digits[7:4]), 32'd1);

        phase = "scan";
        u0 = n_upd;
        f0 = n_frame_obs;
        hold(4'b1110, 7'b1011000, 6);
        hold(4'b1101, 7'b0110000, 6);
        hold(4'b1011, 7'b0010000, 6);
        hold(4'b0111, 7'b0010010, 6);
        check("four_updates", 32'(n_upd - u0), 32'd4);
        check("one_frame", 32'(n_frame_obs - f0), 32'd1);
        check("frame_on_fourth", 32'(frame_at), 32'(u0 + 4));
        check("digits_5937", 32'(bus.o_digits), 32'h5937);

        phase = "illegal";
        u0 = n_upd;
        e0 = n_err_obs;
        hold(4'b0111, 7'b1010101, 6);
        check("illegal_update", 32'(n_upd - u0), 32'd1);
        check("illegal_err", 32'(n_err_obs - e0), 32'd1);
        check("digit3_kept", 32'(bus.o_digits[15:12]), 32'd5);
        check("valid3_clear", 32'(bus.o_valid[3]), 32'd0);

        phase = "gap";
        u0 = n_upd;
        hold(4'b1111, 7'b0000000, 10);
        hold(4'b1100, 7'b0000000, 10);
        check("gap_no_capture", 32'(n_upd - u0), 32'd0);

        phase = "reset_mid";
        hold(4'b1110, 7'b0000000, 3);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2;
        check_outputs();
        rst   = 1'b0;
        found = -1;
        for (int k = 0; k < 20; k++) begin
            step(4'b1110, 7'b0000000);
            if (bus.o_update === 1'b1) begin
                found = k;
                break;
            end
        end
        check("recapture_edge", 32'(found), 32'(SC));
        check("digit0_is_8", 32'(bus.o_digits[3:0]), 32'd8);

        phase = "blank";
        e0 = n_err_obs;
        hold(4'b1011, 7'b1111111, 6);
`ifdef SEG7_BLANK_EN
        check("blank_digit2_f", 32'(bus.o_digits[11:8]), 32'hF);
        check("blank_valid2", 32'(bus.o_valid[2]), 32'd1);
        check("blank_no_err", 32'(n_err_obs - e0), 32'd0);
`else
        check("blank_err", 32'(n_err_obs - e0), 32'd1);
        check("blank_valid2", 32'(bus.o_valid[2]), 32'd0);
`endif

        phase = "random";
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 4) == 0) ran = 4'($urandom_range(0, 15));
            else                           ran = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) rseg = 7'($urandom_range(0, 127));
            else                           rseg = pat_tab[$urandom_range(0, 9)];
            hold(ran, rseg, $urandom_range(1, 8));
        end

        phase = "drain";
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode strobes) and recovers the decimal digit shown on each position. It is the receive-side counterpart of our decimal-to-segment decoder: the same segment encoding is inverted back to 4-bit values. It sits between a scanned display driver (or external panel pins) and logic or a checker that needs the displayed numbers. Segment inputs are debounced per strobe, captured per digit, and reported with update, error and frame-complete pulses.

## Interface
- NUM_DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before capture (>=1).
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_seg7  in  7  segment lines, active-low, bit0=a .. bit6=g.
- i_an  in  NUM_DIGITS  digit strobes, active-low; exactly one low selects a digit.
- o_digits  out  4*NUM_DIGITS  captured values; digit n at [4n+3:4n].
- o_valid  out  NUM_DIGITS  bit n high when digit n holds a legal decoded value.
- o_update  out  1  one-cycle pulse on every capture.
- o_err  out  1  one-cycle pulse when a capture saw an illegal segment pattern.
- o_frame  out  1  one-cycle pulse when every digit has been captured since the previous pulse.

## Operation
- Sample register r holds {i_an, i_seg7} from the previous edge; it is loaded on every edge.
- Stability counter cnt, width clog2(STABLE_CYCLES)+1: cleared when {i_an,i_seg7} != r, otherwise incremented, saturating at STABLE_CYCLES-1.
- Anode is "selected" when i_an has exactly one zero bit; all-ones or multiple zeros is a gap.
- FSM, three states:
  - IDLE: no selected anode. Goes to SETTLE once i_an is selected.
  - SETTLE: counting. A capture fires on an edge where the input is selected, equals r, and cnt == STABLE_CYCLES-1; the FSM then goes to HELD. An input change keeps it in SETTLE with cnt cleared. A gap returns it to IDLE.
  - HELD: no further captures for the same {an,seg}. An input change goes to SETTLE, or to IDLE on a gap.
- On a capture of digit n with a legal pattern, the pattern is decoded as follows:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1011000=7, 0000000=8, 0010000=9.
  - The 4-bit value is written to digit n, o_valid[n] is set, and o_update pulses.
- On a capture with an illegal pattern: digit n is unchanged, o_valid[n] is cleared, and o_update and o_err both pulse.
- Frame tracking:
  - A seen mask sets bit n on any capture of digit n.
  - When the mask becomes all-ones, o_frame pulses on the same cycle as that o_update, and the mask clears.
  - Re-capturing an already seen digit does not clear the mask.

## Timing
- Reset values:
  - o_digits=0, o_valid=0, o_update=0, o_err=0, o_frame=0.
  - FSM=IDLE, cnt=0, r=all-ones, seen mask=0.
- Latency, with a new input first sampled at edge 0 and held: the capture edge is edge STABLE_CYCLES. o_digits, o_valid and the pulses are registered and visible after that edge for one cycle (the pulses) or until the next capture (the data).
- A change on any edge before capture restarts the count; glitches shorter than STABLE_CYCLES+1 samples are never captured.
- A change from digit n to digit m without a gap goes directly into SETTLE for m.
- Reset asserted mid-count or mid-HELD forces all reset values immediately; no capture occurs on the edge reset is released.
- All captured values are held indefinitely through gaps.

## Configuration
- SEG7_BLANK_EN defined: the all-off pattern 1111111 is legal. It decodes to 4'hF, sets o_valid[n], and does not pulse o_err.
- SEG7_BLANK_EN undefined: 1111111 is illegal and handled as any other illegal pattern.

## Test plan
- Reset check, STABLE_CYCLES=4: hold an=1110, seg=0100100 from edge 0. Required: o_update pulses after edge 4; digit0=2; o_valid=0001.
- Glitch check: seg=0110000 held for 3 samples, then 1111001 held for 10 samples, on an=1101. Required: a single capture, digit1=1; no capture of 3.
- Full scan check: drive 7,3,9,5 on digits 0..3, 6 cycles each, no gaps. Required:
  - four o_update pulses;
  - o_frame coincides with the fourth pulse;
  - o_digits=16'h5937.
- Illegal pattern check: seg=1010101 on an=0111. Required: o_err and o_update pulse; digit3 unchanged; o_valid[3]=0.
- Gap and reset check:
  - an=1111 or an=1100 for 20 cycles. Required: no captures.
  - Assert i_reset at cnt=2. Required: all outputs 0; a re-held input captures STABLE_CYCLES edges after release.
- Blank pattern check: seg=1111111 on digit 2. Required with SEG7_BLANK_EN: digit2=F, valid, no o_err. Required without it: o_err pulses.
